// File: rtl/line_follow_pkg.sv
// Shared definitions for the line-follow motion controller.
//   mode_e  : FSM state encoding, also driven out on the mode port
//   TRK_*   : direction codes from the tracker sensor block
//   turn_e  : remembered direction of the most recent turn
package line_follow_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FWD    = 3'd1,
        TURN_L = 3'd2,
        TURN_R = 3'd3,
        COAST  = 3'd4,
        SEARCH = 3'd5,
        HALT   = 3'd6
    } mode_e;

    localparam logic [1:0] TRK_NONE  = 2'b00;
    localparam logic [1:0] TRK_LEFT  = 2'b01;
    localparam logic [1:0] TRK_RIGHT = 2'b10;
    localparam logic [1:0] TRK_FWD   = 2'b11;

    typedef enum logic {
        TURN_LEFT  = 1'b0,
        TURN_RIGHT = 1'b1
    } turn_e;

    // Modes in which the motors must be stopped immediately.
    function automatic logic is_stopped(input mode_e m);
        return (m == IDLE) || (m == HALT);
    endfunction

endpackage

// File: rtl/line_follow_ctrl_pwm_gen.sv
// Shared PWM generator for both wheels: one free-running counter and two
// comparators. Duties are taken from the targets only at counter wrap so a
// period is never cut short; force_zero_i bypasses that and stops both
// outputs on the next edge.
//   clk, reset            : clock, async active-high reset
//   force_zero_i          : clear active duties and outputs now
//   duty_l_i / duty_r_i   : target duties (cycles high per period)
//   pwm_l_o / pwm_r_o     : registered PWM outputs
module pwm_gen #(
    parameter int PWM_W      = 10,
    parameter int PWM_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             force_zero_i,
    input  logic [PWM_W-1:0] duty_l_i,
    input  logic [PWM_W-1:0] duty_r_i,
    output logic             pwm_l_o,
    output logic             pwm_r_o
);

    localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(PWM_PERIOD - 1);

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic [PWM_W-1:0] duty_l_q, duty_l_d;
    logic [PWM_W-1:0] duty_r_q, duty_r_d;
    logic             wrap;

    assign wrap = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        duty_l_d = duty_l_q;
        duty_r_d = duty_r_q;
        if (force_zero_i) begin
            duty_l_d = '0;
            duty_r_d = '0;
        end else if (wrap) begin
            duty_l_d = duty_l_i;
            duty_r_d = duty_r_i;
        end
    end

    // Compare against next-state values so the registered output lines up
    // with the counter value it represents. Duty >= period gives a
    // constantly high output since the counter never reaches it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            duty_l_q <= '0;
            duty_r_q <= '0;
            pwm_l_o  <= 1'b0;
            pwm_r_o  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            duty_l_q <= duty_l_d;
            duty_r_q <= duty_r_d;
            pwm_l_o  <= (cnt_d < duty_l_d);
            pwm_r_o  <= (cnt_d < duty_r_d);
        end
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-follow motion controller. Debounces the tracker direction code,
// sequences IDLE/FWD/TURN/COAST/SEARCH/HALT, and drives per-wheel PWM and
// direction pins.
//   clk, reset        : clock, async active-high reset
//   enable            : run request, low forces IDLE
//   obstacle          : forces HALT from any non-IDLE mode
//   track_state       : tracker code (00 none, 01 left, 10 right, 11 fwd)
//   left/right_pwm    : motor PWM
//   left/right_dir    : 1 forward, 0 reverse
//   mode, halted      : current state, HALT indicator
module line_follow_ctrl
    import line_follow_pkg::*;
#(
    parameter int PWM_W           = 10,
    parameter int PWM_PERIOD      = 1000,
    parameter int FAST_DUTY       = 800,
    parameter int SLOW_DUTY       = 300,
    parameter int SEARCH_DUTY     = 500,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOST_CYCLES     = 5000000,
    parameter int SEARCH_CYCLES   = 100000000,
    parameter int TMR_W           = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       obstacle,
    input  logic [1:0] track_state,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic       left_dir,
    output logic       right_dir,
    output logic [2:0] mode,
    output logic       halted
);

    localparam int               DB_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [DB_W-1:0]  DB_FULL   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOST_LAST = TMR_W'(LOST_CYCLES - 1);
    localparam logic [TMR_W-1:0] SRCH_LAST = TMR_W'(SEARCH_CYCLES - 1);
    localparam logic [PWM_W-1:0] FAST_D    = PWM_W'(FAST_DUTY);
    localparam logic [PWM_W-1:0] SLOW_D    = PWM_W'(SLOW_DUTY);
    localparam logic [PWM_W-1:0] SRCH_D    = PWM_W'(SEARCH_DUTY);

    // ---------------- debounce ----------------
    // The loading edge counts as the first stable sample, so the accepted
    // code updates on the DEBOUNCE_CYCLES-th edge of a steady input.
    logic [1:0]      cand_q, acc_q;
    logic [DB_W-1:0] db_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q   <= TRK_NONE;
            acc_q    <= TRK_NONE;
            db_cnt_q <= '0;
        end else if (track_state != cand_q) begin
            cand_q   <= track_state;
            db_cnt_q <= '0;
        end else if (db_cnt_q != DB_FULL) begin
            db_cnt_q <= db_cnt_q + 1'b1;
            if (db_cnt_q == DB_LAST) acc_q <= cand_q;
        end
    end

    // ---------------- mode FSM ----------------
    mode_e            mode_q, mode_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    turn_e            last_turn_q;
    logic [PWM_W-1:0] tgt_l_q, tgt_r_q;
    logic             ldir_q, rdir_q, halted_q;
    logic             stop_d;

    function automatic mode_e follow(input logic [1:0] code);
        case (code)
            TRK_FWD:   return FWD;
            TRK_LEFT:  return TURN_L;
            TRK_RIGHT: return TURN_R;
            default:   return COAST;
        endcase
    endfunction

    always_comb begin
        mode_d = mode_q;
        if (obstacle && mode_q != IDLE) begin
            mode_d = HALT;
        end else if (!enable) begin
            mode_d = IDLE;
        end else begin
            case (mode_q)
                IDLE, FWD, TURN_L, TURN_R: mode_d = follow(acc_q);
                COAST: begin
                    if (acc_q != TRK_NONE)   mode_d = follow(acc_q);
                    else if (tmr_q == LOST_LAST) mode_d = SEARCH;
                end
                SEARCH: begin
                    if (acc_q != TRK_NONE)   mode_d = follow(acc_q);
                    else if (tmr_q == SRCH_LAST) mode_d = HALT;
                end
                default: mode_d = mode_q;
            endcase
        end
        // Timer only runs while dwelling in COAST/SEARCH; any mode change
        // restarts it.
        if (mode_d != mode_q)                  tmr_d = '0;
        else if (mode_q inside {COAST, SEARCH}) tmr_d = tmr_q + 1'b1;
        else                                   tmr_d = '0;
    end

    assign stop_d = is_stopped(mode_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= IDLE;
            tmr_q       <= '0;
            last_turn_q <= TURN_RIGHT;
            tgt_l_q     <= '0;
            tgt_r_q     <= '0;
            ldir_q      <= 1'b1;
            rdir_q      <= 1'b1;
            halted_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            tmr_q    <= tmr_d;
            halted_q <= (mode_d == HALT);
            if (mode_d == TURN_L)      last_turn_q <= TURN_LEFT;
            else if (mode_d == TURN_R) last_turn_q <= TURN_RIGHT;
            case (mode_d)
                FWD:    begin tgt_l_q <= FAST_D; tgt_r_q <= FAST_D; end
                TURN_L: begin tgt_l_q <= SLOW_D; tgt_r_q <= FAST_D; end
                TURN_R: begin tgt_l_q <= FAST_D; tgt_r_q <= SLOW_D; end
                SEARCH: begin tgt_l_q <= SRCH_D; tgt_r_q <= SRCH_D; end
                COAST:  ;  // keep whatever motion was in progress
                default: begin tgt_l_q <= '0; tgt_r_q <= '0; end
            endcase
            // Search spins in place: the wheel on the turn side reverses.
            if (mode_d == SEARCH) begin
                ldir_q <= (last_turn_q == TURN_RIGHT);
                rdir_q <= (last_turn_q == TURN_LEFT);
            end else begin
                ldir_q <= 1'b1;
                rdir_q <= 1'b1;
            end
        end
    end

    pwm_gen #(
        .PWM_W      (PWM_W),
        .PWM_PERIOD (PWM_PERIOD)
    ) u_pwm (
        .clk          (clk),
        .reset        (reset),
        .force_zero_i (stop_d),
        .duty_l_i     (tgt_l_q),
        .duty_r_i     (tgt_r_q),
        .pwm_l_o      (left_pwm),
        .pwm_r_o      (right_pwm)
    );

    assign mode      = mode_q;
    assign halted    = halted_q;
    assign left_dir  = ldir_q;
    assign right_dir = rdir_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl with small timing parameters:
// period 10, duties 8/3/5, debounce 4, lost 20, search 50.
module tb_line_follow_ctrl;
    import line_follow_pkg::*;

    logic       clk = 1'b0;
    logic       reset, enable, obstacle;
    logic [1:0] track_state;
    logic       left_pwm, right_pwm, left_dir, right_dir, halted;
    logic [2:0] mode;

    int total = 0;
    int bad   = 0;

    line_follow_ctrl #(
        .PWM_W(10), .PWM_PERIOD(10), .FAST_DUTY(8), .SLOW_DUTY(3),
        .SEARCH_DUTY(5), .DEBOUNCE_CYCLES(4), .LOST_CYCLES(20),
        .SEARCH_CYCLES(50), .TMR_W(27)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .obstacle(obstacle),
        .track_state(track_state), .left_pwm(left_pwm), .right_pwm(right_pwm),
        .left_dir(left_dir), .right_dir(right_dir), .mode(mode), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       obs;
        logic [1:0] trk;
        mode_e      mode;
        logic       hlt;
        logic       ldir;
        logic       rdir;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic en, input logic obs, input logic [1:0] trk,
                        input mode_e m, input logic h, input logic ld, input logic rd);
        vec_t v;
        v.en = en; v.obs = obs; v.trk = trk; v.mode = m; v.hlt = h; v.ldir = ld; v.rdir = rd;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            enable = vecs[i].en; obstacle = vecs[i].obs; track_state = vecs[i].trk;
            step();
            chk($sformatf("vec%0d", i), {mode, halted, left_dir, right_dir},
                {vecs[i].mode, vecs[i].hlt, vecs[i].ldir, vecs[i].rdir});
        end
    endtask

    task automatic measure(input int n, output int l, output int r);
        l = 0; r = 0;
        repeat (n) begin
            step();
            l += int'(left_pwm);
            r += int'(right_pwm);
        end
    endtask

    // From the edge that entered COAST: 19 more cycles in COAST, then SEARCH.
    // Returns the PWM high count over the first 10 of those cycles.
    task automatic coast_run(input string nm, output int l, output int r);
        logic ok;
        ok = 1'b1; l = 0; r = 0;
        for (int k = 1; k <= 19; k++) begin
            step();
            if (mode !== COAST) ok = 1'b0;
            if (k <= 10) begin
                l += int'(left_pwm);
                r += int'(right_pwm);
            end
        end
        chk({nm, "_coast_hold"}, ok, 1'b1);
        step();
        chk({nm, "_to_search"}, mode, SEARCH);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l, r, guard;
        logic prev, found, ok;

        // A: startup with steady forward code (IDLE->COAST on code 00 first)
        addv(1,0,TRK_FWD, COAST,0,1,1);
        addv(1,0,TRK_FWD, COAST,0,1,1);
        addv(1,0,TRK_FWD, COAST,0,1,1);
        addv(1,0,TRK_FWD, COAST,0,1,1);
        addv(1,0,TRK_FWD, FWD,  0,1,1);
        addv(1,0,TRK_FWD, FWD,  0,1,1);
        // B: 3-cycle left glitches ignored, then 4-cycle left accepted
        for (int i = 0; i < 3; i++) addv(1,0,TRK_LEFT, FWD,0,1,1);
        for (int i = 0; i < 2; i++) addv(1,0,TRK_FWD,  FWD,0,1,1);
        for (int i = 0; i < 3; i++) addv(1,0,TRK_LEFT, FWD,0,1,1);
        addv(1,0,TRK_FWD, FWD,0,1,1);
        for (int i = 0; i < 4; i++) addv(1,0,TRK_LEFT, FWD,0,1,1);
        addv(1,0,TRK_LEFT, TURN_L,0,1,1);
        // C: obstacle with enable fall, obstacle ignored in IDLE, resume
        addv(0,1,TRK_FWD, HALT,1,1,1);
        addv(0,0,TRK_FWD, IDLE,0,1,1);
        addv(0,1,TRK_FWD, IDLE,0,1,1);
        addv(1,0,TRK_FWD, FWD, 0,1,1);

        reset = 1'b1; enable = 1'b0; obstacle = 1'b0; track_state = TRK_NONE;
        step(); step();
        chk("rst_mode",   mode, IDLE);
        chk("rst_pwm",    {left_pwm, right_pwm}, 2'b00);
        chk("rst_dir",    {left_dir, right_dir}, 2'b11);
        chk("rst_halted", halted, 1'b0);
        reset = 1'b0;

        // 1: forward
        run_vecs(0, 5);
        measure(10, l, r);
        measure(10, l, r);
        chk("fwd_pwm", {l[7:0], r[7:0]}, {8'd8, 8'd8});

        // 2: glitches then left turn
        run_vecs(6, 19);
        measure(10, l, r);
        measure(10, l, r);
        chk("turnl_pwm", {l[7:0], r[7:0]}, {8'd3, 8'd8});

        // 3: right turn, line lost, coast, search, halt
        track_state = TRK_RIGHT;
        repeat (4) step();
        chk("turnr_wait", mode, TURN_L);
        step();
        chk("turnr", mode, TURN_R);
        measure(10, l, r);
        measure(10, l, r);
        chk("turnr_pwm", {l[7:0], r[7:0]}, {8'd8, 8'd3});
        track_state = TRK_NONE;
        repeat (4) step();
        chk("lost_wait", mode, TURN_R);
        step();
        chk("coast", mode, COAST);
        coast_run("s3", l, r);
        chk("coast_pwm", {l[7:0], r[7:0]}, {8'd8, 8'd3});
        chk("search_dir", {left_dir, right_dir}, 2'b10);
        measure(10, l, r);
        measure(10, l, r);
        chk("search_pwm", {l[7:0], r[7:0]}, {8'd5, 8'd5});
        ok = 1'b1;
        repeat (29) begin
            step();
            if (mode !== SEARCH) ok = 1'b0;
        end
        chk("search_hold", ok, 1'b1);
        step();
        chk("halt_mode", {mode, halted}, {HALT, 1'b1});
        chk("halt_pwm_now", {left_pwm, right_pwm}, 2'b00);
        measure(10, l, r);
        chk("halt_pwm", {l[7:0], r[7:0]}, 16'd0);

        // 4: recover from search
        enable = 1'b0;
        step();
        chk("idle_from_halt", {mode, halted}, {IDLE, 1'b0});
        enable = 1'b1;
        step();
        chk("coast2", mode, COAST);
        coast_run("s4", l, r);
        chk("search2_dir", {left_dir, right_dir}, 2'b10);
        track_state = TRK_FWD;
        repeat (4) step();
        chk("found_wait", mode, SEARCH);
        step();
        chk("found_fwd", {mode, left_dir, right_dir}, {FWD, 2'b11});
        measure(10, l, r);
        measure(10, l, r);
        chk("found_pwm", {l[7:0], r[7:0]}, {8'd8, 8'd8});

        // 5: obstacle pulse mid-period (just after PWM rises)
        found = 1'b0; guard = 0;
        while (!found && guard < 30) begin
            prev = left_pwm;
            step();
            guard++;
            if (!prev && left_pwm) found = 1'b1;
        end
        chk("pwm_rise_seen", found, 1'b1);
        obstacle = 1'b1;
        step();
        chk("obs_halt", {mode, halted}, {HALT, 1'b1});
        chk("obs_pwm0", {left_pwm, right_pwm}, 2'b00);
        obstacle = 1'b0;
        repeat (3) step();
        chk("obs_stay", {mode, halted}, {HALT, 1'b1});
        enable = 1'b0;
        step();
        chk("obs_idle", mode, IDLE);
        enable = 1'b1;
        step();
        chk("obs_resume", mode, FWD);
        run_vecs(20, 23);

        // 6: reset in the middle of COAST
        track_state = TRK_NONE;
        repeat (4) step();
        step();
        chk("coast3", mode, COAST);
        repeat (10) step();
        reset = 1'b1;
        #1;
        chk("mid_rst", {mode, halted, left_dir, right_dir, left_pwm, right_pwm},
            {IDLE, 1'b0, 2'b11, 2'b00});
        step();
        reset = 1'b0;
        step();
        chk("post_rst_coast", mode, COAST);
        coast_run("s6", l, r);
        chk("post_rst_pwm", {l[7:0], r[7:0]}, 16'd0);
        chk("post_rst_dir", {left_dir, right_dir}, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
